// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch squash and memory-wait freeze.
// Optional performance counters are enabled with the HAZ_PERF_CNT_EN macro.
module hazard_ctrl #(
    parameter int unsigned LOADUSE_BUBBLES     = 1,
    parameter int unsigned BRANCH_FLUSH_CYCLES = 1,
    parameter int unsigned MAX_MEM_WAIT        = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        rt_used_id,
    input  logic        ex_is_load,
    input  logic        ex_wr_en_reg,
    input  logic [4:0]  ex_wr_num,
    input  logic        branch_taken_ex,
    input  logic        dm_busy,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic [1:0]  hz_state,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_t;

    localparam logic [2:0] LU_RELOAD  = 3'(LOADUSE_BUBBLES - 1);
    localparam logic [2:0] BR_RELOAD  = 3'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_MEM_WAIT);

    hz_state_t  state_r, state_nxt_s;
    hz_state_t  saved_state_r, saved_state_nxt_s;
    hz_state_t  eff_state_s;
    logic [2:0] cnt_r, cnt_nxt_s;
    logic [2:0] saved_cnt_r, saved_cnt_nxt_s;
    logic [2:0] eff_cnt_s;
    logic [7:0] wait_cnt_r, wait_cnt_nxt_s;
    logic       mem_timeout_r, mem_timeout_nxt_s;
    logic       load_use_s;
    logic       pc_stall_s, if_id_stall_s, if_id_flush_s;
    logic       id_ex_stall_s, id_ex_flush_s, ex_mem_stall_s;

    assign load_use_s = ex_is_load && ex_wr_en_reg && (ex_wr_num != 5'd0) &&
                        ((ex_wr_num == rs_id) || (rt_used_id && (ex_wr_num == rt_id)));

    // Next-state, counters and control outputs from the current state and inputs.
    always_comb begin
        pc_stall_s        = 1'b0;
        if_id_stall_s     = 1'b0;
        if_id_flush_s     = 1'b0;
        id_ex_stall_s     = 1'b0;
        id_ex_flush_s     = 1'b0;
        ex_mem_stall_s    = 1'b0;
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_r;
        saved_state_nxt_s = saved_state_r;
        saved_cnt_nxt_s   = saved_cnt_r;
        wait_cnt_nxt_s    = wait_cnt_r;
        mem_timeout_nxt_s = mem_timeout_r;

        // Leaving a memory wait resumes the interrupted state in the same cycle.
        if (state_r == ST_MEM_WAIT) begin
            eff_state_s = saved_state_r;
            eff_cnt_s   = saved_cnt_r;
        end else begin
            eff_state_s = state_r;
            eff_cnt_s   = cnt_r;
        end

        if (rst) begin
            state_nxt_s       = ST_IDLE;
            cnt_nxt_s         = 3'd0;
            saved_state_nxt_s = ST_IDLE;
            saved_cnt_nxt_s   = 3'd0;
            wait_cnt_nxt_s    = 8'd0;
            mem_timeout_nxt_s = 1'b0;
        end else if (dm_busy) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
            state_nxt_s    = ST_MEM_WAIT;
            if (state_r != ST_MEM_WAIT) begin
                saved_state_nxt_s = state_r;
                saved_cnt_nxt_s   = cnt_r;
            end else begin
                saved_state_nxt_s = saved_state_r;
                saved_cnt_nxt_s   = saved_cnt_r;
            end
            if (wait_cnt_r == 8'hFF) begin
                wait_cnt_nxt_s = 8'hFF;
            end else begin
                wait_cnt_nxt_s = wait_cnt_r + 8'd1;
            end
            if (wait_cnt_nxt_s >= WAIT_LIMIT) begin
                mem_timeout_nxt_s = 1'b1;
            end else begin
                mem_timeout_nxt_s = mem_timeout_r;
            end
        end else begin
            wait_cnt_nxt_s    = 8'd0;
            saved_state_nxt_s = ST_IDLE;
            saved_cnt_nxt_s   = 3'd0;
            if (branch_taken_ex) begin
                if_id_flush_s = 1'b1;
                id_ex_flush_s = 1'b1;
                if (BRANCH_FLUSH_CYCLES > 1) begin
                    state_nxt_s = ST_BR_FLUSH;
                    cnt_nxt_s   = BR_RELOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 3'd0;
                end
            end else begin
                case (eff_state_s)
                    ST_LU_STALL: begin
                        pc_stall_s    = 1'b1;
                        if_id_stall_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                        if (eff_cnt_s <= 3'd1) begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = 3'd0;
                        end else begin
                            state_nxt_s = ST_LU_STALL;
                            cnt_nxt_s   = eff_cnt_s - 3'd1;
                        end
                    end
                    ST_BR_FLUSH: begin
                        if_id_flush_s = 1'b1;
                        if (eff_cnt_s <= 3'd1) begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = 3'd0;
                        end else begin
                            state_nxt_s = ST_BR_FLUSH;
                            cnt_nxt_s   = eff_cnt_s - 3'd1;
                        end
                    end
                    ST_IDLE: begin
                        if (load_use_s) begin
                            pc_stall_s    = 1'b1;
                            if_id_stall_s = 1'b1;
                            id_ex_flush_s = 1'b1;
                            if (LOADUSE_BUBBLES > 1) begin
                                state_nxt_s = ST_LU_STALL;
                                cnt_nxt_s   = LU_RELOAD;
                            end else begin
                                state_nxt_s = ST_IDLE;
                                cnt_nxt_s   = 3'd0;
                            end
                        end else begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = 3'd0;
                        end
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 3'd0;
                    end
                endcase
            end
        end
    end

    // State, saved context, wait counter and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 3'd0;
            saved_state_r <= ST_IDLE;
            saved_cnt_r   <= 3'd0;
            wait_cnt_r    <= 8'd0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            saved_state_r <= saved_state_nxt_s;
            saved_cnt_r   <= saved_cnt_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_nxt_s;
        end
    end

    assign pc_stall     = pc_stall_s;
    assign if_id_stall  = if_id_stall_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_stall  = id_ex_stall_s;
    assign id_ex_flush  = id_ex_flush_s;
    assign ex_mem_stall = ex_mem_stall_s;
    assign hz_state     = state_r;
    assign mem_timeout  = mem_timeout_r;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;
    logic        flush_prev_r;

    // Saturating stall-cycle and flush-event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
            flush_prev_r <= 1'b0;
        end else begin
            if (pc_stall_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if (id_ex_flush_s && !flush_prev_r && (perf_flush_r != 32'hFFFF_FFFF)) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end
            flush_prev_r <= id_ex_flush_s;
        end
    end

    assign perf_stall_cycles = perf_stall_r;
    assign perf_flush_events = perf_flush_r;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, memory-timeout
// sequence and randomized traffic against a counter-based reference model.
module tb_hazard_ctrl;

    localparam int LUB  = 3;
    localparam int BFC  = 3;
    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_id, rt_id, ex_wr_num;
    logic        rt_used_id, ex_is_load, ex_wr_en_reg, branch_taken_ex, dm_busy;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic [1:0]  hz_state;
    logic        mem_timeout;
    logic [31:0] perf_stall_cycles, perf_flush_events;

    hazard_ctrl #(
        .LOADUSE_BUBBLES(LUB),
        .BRANCH_FLUSH_CYCLES(BFC),
        .MAX_MEM_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .rt_used_id(rt_used_id),
        .ex_is_load(ex_is_load), .ex_wr_en_reg(ex_wr_en_reg), .ex_wr_num(ex_wr_num),
        .branch_taken_ex(branch_taken_ex), .dm_busy(dm_busy),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .hz_state(hz_state), .mem_timeout(mem_timeout),
        .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic       ru, ld, we;
        logic [4:0] wn;
        logic       br, bz;
        logic [5:0] ctrl;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    // Reference model: remaining bubbles/flushes, busy-run length, sticky timeout.
    int lu_left = 0, br_left = 0, busy_run = 0;
    int m_tout = 0, m_ps = 0, m_pf = 0, m_prev = 0;
    int lu_pc_tally = 0;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ru,
                                input logic ld, input logic we, input logic [4:0] wn,
                                input logic br, input logic bz, input logic [5:0] ctrl,
                                input logic [1:0] st);
        vec_t v;
        v.rs = rs; v.rt = rt; v.ru = ru; v.ld = ld; v.we = we; v.wn = wn;
        v.br = br; v.bz = bz; v.ctrl = ctrl; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: compare with model, 1: compare with table entry, 2: no compare
    task automatic step(input vec_t v, input logic r, input int mode, input string tag);
        logic [5:0] ectrl;
        logic [1:0] est;
        logic       lu_m;
        logic [5:0] act;
        rst = r; rs_id = v.rs; rt_id = v.rt; rt_used_id = v.ru; ex_is_load = v.ld;
        ex_wr_en_reg = v.we; ex_wr_num = v.wn; branch_taken_ex = v.br; dm_busy = v.bz;
        #1;
        lu_m = v.ld && v.we && (v.wn != 5'd0) && ((v.wn == v.rs) || (v.ru && (v.wn == v.rt)));
        est = (busy_run > 0) ? 2'd3 : (lu_left > 0) ? 2'd1 : (br_left > 0) ? 2'd2 : 2'd0;
        if (r) ectrl = 6'b000000;
        else if (v.bz) ectrl = 6'b110101;
        else if (v.br) ectrl = 6'b001010;
        else if (lu_left > 0) ectrl = 6'b110010;
        else if (br_left > 0) ectrl = 6'b001000;
        else if (lu_m) ectrl = 6'b110010;
        else ectrl = 6'b000000;
        act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};
        if (mode == 0) begin
            check({tag, "_ctrl"}, 32'(act), 32'(ectrl));
            if (!r) begin
                check({tag, "_state"}, 32'(hz_state), 32'(est));
                check({tag, "_tout"}, 32'(mem_timeout), 32'(m_tout));
`ifdef HAZ_PERF_CNT_EN
                check({tag, "_pstall"}, perf_stall_cycles, 32'(m_ps));
                check({tag, "_pflush"}, perf_flush_events, 32'(m_pf));
`else
                check({tag, "_pstall"}, perf_stall_cycles, 32'd0);
                check({tag, "_pflush"}, perf_flush_events, 32'd0);
`endif
            end
        end else if (mode == 1) begin
            check({tag, "_ctrl"}, 32'(act), 32'(v.ctrl));
            check({tag, "_state"}, 32'(hz_state), 32'(v.st));
            check({tag, "_tout"}, 32'(mem_timeout), 32'd0);
            if (pc_stall === 1'b1) lu_pc_tally++;
        end
        // model update
        if (r) begin
            lu_left = 0; br_left = 0; busy_run = 0; m_tout = 0; m_ps = 0; m_pf = 0; m_prev = 0;
        end else begin
            if (v.bz) begin
                if (busy_run < 255) busy_run++;
                if (busy_run >= MAXW) m_tout = 1;
            end else begin
                busy_run = 0;
                if (v.br) begin br_left = BFC - 1; lu_left = 0; end
                else if (lu_left > 0) lu_left--;
                else if (br_left > 0) br_left--;
                else if (lu_m) lu_left = LUB - 1;
            end
            m_ps += int'(ectrl[5]);
            if (ectrl[1] && m_prev == 0) m_pf++;
            m_prev = int'(ectrl[1]);
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t idle, ld5, bz1, rv;
        int bl;
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0, 2'd0);
        ld5  = mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 6'd0, 2'd0);
        bz1  = idle; bz1.bz = 1'b1;

        tbl.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 6'b110010, 2'd0));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, 2'd1));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, 2'd1));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, 2'd0));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 6'b000000, 2'd0));
        tbl.push_back(mk(5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 6'b000000, 2'd0));
        tbl.push_back(mk(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 6'b110010, 2'd0));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, 2'd1));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, 2'd1));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, 2'd0));
        tbl.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 6'b001010, 2'd0));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b001000, 2'd2));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b001000, 2'd2));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, 2'd0));
        // load-use interrupted by a 4-cycle memory wait on its second bubble
        tbl.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 6'b110010, 2'd0));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b110101, 2'd1));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b110101, 2'd3));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b110101, 2'd3));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b110101, 2'd3));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, 2'd3));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, 2'd1));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, 2'd0));
        tbl.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 6'b000000, 2'd0));
        // branch arriving during a load-use stall
        tbl.push_back(mk(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 6'b110010, 2'd0));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 6'b001010, 2'd1));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b001000, 2'd2));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b001000, 2'd2));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, 2'd0));

        @(negedge clk);
        // reset with busy and branch active
        rv = idle; rv.bz = 1'b1; rv.br = 1'b1;
        step(rv, 1'b1, 0, "rst0");
        check("rst_state", 32'(hz_state), 32'd0);
        check("rst_tout", 32'(mem_timeout), 32'd0);
        step(rv, 1'b1, 0, "rst1");

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 14) lu_pc_tally = 0;
            step(tbl[i], 1'b0, 1, $sformatf("vec%0d", i));
            if (i == 20) check("lu_busy_pc_total", 32'(lu_pc_tally), 32'd7);
        end

        // memory timeout: 20 busy cycles, then idle, then reset
        step(idle, 1'b1, 2, "trst");
        for (int k = 0; k < 20; k++) begin
            step(bz1, 1'b0, 0, $sformatf("busy%0d", k));
            check($sformatf("tout_after%0d", k + 1), 32'(mem_timeout), (k + 1 >= MAXW) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            step(idle, 1'b0, 0, $sformatf("post%0d", k));
            check("tout_sticky", 32'(mem_timeout), 32'd1);
        end
        step(idle, 1'b1, 0, "trst2");
        check("tout_cleared", 32'(mem_timeout), 32'd0);

        // performance counters: two load-use hazards and one branch
        step(ld5, 1'b0, 0, "p_lu1");
        for (int k = 0; k < 3; k++) step(idle, 1'b0, 0, "p_i1");
        step(ld5, 1'b0, 0, "p_lu2");
        for (int k = 0; k < 3; k++) step(idle, 1'b0, 0, "p_i2");
        rv = idle; rv.br = 1'b1;
        step(rv, 1'b0, 0, "p_br");
        for (int k = 0; k < 3; k++) step(idle, 1'b0, 0, "p_i3");
`ifdef HAZ_PERF_CNT_EN
        check("perf_stall_total", perf_stall_cycles, 32'(2 * LUB));
        check("perf_flush_total", perf_flush_events, 32'd3);
`else
        check("perf_stall_total", perf_stall_cycles, 32'd0);
        check("perf_flush_total", perf_flush_events, 32'd0);
`endif

        // randomized traffic
        bl = 0;
        for (int n = 0; n < 3000; n++) begin
            rv = idle;
            rv.rs = 5'($urandom_range(0, 3));
            rv.rt = 5'($urandom_range(0, 3));
            rv.wn = 5'($urandom_range(0, 3));
            rv.ru = 1'($urandom_range(0, 1));
            rv.ld = 1'($urandom_range(0, 1));
            rv.we = ($urandom_range(0, 3) != 0);
            rv.br = ($urandom_range(0, 11) == 0);
            if (bl == 0 && $urandom_range(0, 9) == 0)
                bl = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(1, 4);
            rv.bz = (bl > 0);
            if (bl > 0) bl--;
            step(rv, ($urandom_range(0, 399) == 0), 0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
